// File: rtl/dms_ctrl.sv
// dms_ctrl -- serial stream sequencer for a key-configured decryptor.
//
// Accepts a key configuration (size exponent n, private exponent word d,
// modulus word caps) and shifts it out MSB-first on str while mode=1:
// 4 bits of n, then K=2**n bits of d, then K bits of caps. It then accepts
// message bits one at a time and encodes each as a pulse-width symbol of
// SYM_LEN cycles (HI_LONG high cycles for a 1, HI_SHORT for a 0). The last
// bit is followed by a one-cycle closing high on str.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   configuration handshake (cfg_n, cfg_d, cfg_caps)
//   tx_valid/tx_ready     message bit handshake (tx_bit, tx_last)
//   str                   serial stream to the decryptor
//   mode                  1 = configuration phase, 0 = message phase
//   busy                  controller is not idle
//   cfg_err               one-cycle pulse when cfg_n > 5 is offered
//   done                  one-cycle pulse after the closing symbol
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | waiting for a configuration
// S_CFG_N    | shifting n[3:0]
// S_CFG_D    | shifting d[K-1:0]
// S_CFG_CAPS | shifting caps[K-1:0]
// S_MSG_WAIT | waiting for the next message bit
// S_MSG_SYM  | emitting one pulse-width symbol
// S_MSG_END  | closing high cycle after the last bit

module dms_ctrl #(
  parameter int SYM_LEN  = 8,
  parameter int HI_LONG  = 6,
  parameter int HI_SHORT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_n,
  input  logic [31:0] cfg_d,
  input  logic [31:0] cfg_caps,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_bit,
  input  logic        tx_last,
  output logic        str,
  output logic        mode,
  output logic        busy,
  output logic        cfg_err,
  output logic        done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CFG_N    = 3'd1;
  localparam logic [2:0] S_CFG_D    = 3'd2;
  localparam logic [2:0] S_CFG_CAPS = 3'd3;
  localparam logic [2:0] S_MSG_WAIT = 3'd4;
  localparam logic [2:0] S_MSG_SYM  = 3'd5;
  localparam logic [2:0] S_MSG_END  = 3'd6;

  localparam logic [5:0] SYM_LAST = 6'(SYM_LEN - 1);

  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [3:0]  n_lat;
  logic [31:0] d_lat;
  logic [31:0] caps_lat;
  logic        bit_lat;
  logic        last_lat;

  logic [4:0]  k_top;
  logic [4:0]  cnt_m1;
  logic [5:0]  cnt_p1;
  logic [1:0]  nidx;
  logic [5:0]  hi_len;

  // Index of the MSB of a K-bit word; n_lat is at most 5 so this fits.
  assign k_top  = 5'((6'd1 << n_lat) - 6'd1);
  assign cnt_m1 = cnt[4:0] - 5'd1;
  assign cnt_p1 = cnt + 6'd1;
  // n[3] goes out on the handshake edge, so CFG_N counts 0..2 for n[2..0].
  assign nidx   = 2'd2 - cnt[1:0];
  assign hi_len = bit_lat ? 6'(HI_LONG) : 6'(HI_SHORT);

  assign busy = (state != S_IDLE);

  // Outputs are registered: each branch loads the value that belongs to
  // the cycle after the edge, alongside the state/counter update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      d_lat     <= '0;
      caps_lat  <= '0;
      bit_lat   <= 1'b0;
      last_lat  <= 1'b0;
      cfg_ready <= 1'b0;
      tx_ready  <= 1'b0;
      str       <= 1'b0;
      mode      <= 1'b0;
      cfg_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            if (cfg_n > 4'd5) begin
              cfg_err <= 1'b1;
            end else begin
              n_lat     <= cfg_n;
              d_lat     <= cfg_d;
              caps_lat  <= cfg_caps;
              state     <= S_CFG_N;
              cnt       <= '0;
              str       <= cfg_n[3];
              mode      <= 1'b1;
              cfg_ready <= 1'b0;
            end
          end
        end
        S_CFG_N: begin
          if (cnt == 6'd3) begin
            state <= S_CFG_D;
            cnt   <= {1'b0, k_top};
            str   <= d_lat[k_top];
          end else begin
            cnt <= cnt_p1;
            str <= n_lat[nidx];
          end
        end
        S_CFG_D: begin
          if (cnt == 6'd0) begin
            state <= S_CFG_CAPS;
            cnt   <= {1'b0, k_top};
            str   <= caps_lat[k_top];
          end else begin
            cnt <= {1'b0, cnt_m1};
            str <= d_lat[cnt_m1];
          end
        end
        S_CFG_CAPS: begin
          if (cnt == 6'd0) begin
            state    <= S_MSG_WAIT;
            str      <= 1'b0;
            mode     <= 1'b0;
            tx_ready <= 1'b1;
          end else begin
            cnt <= {1'b0, cnt_m1};
            str <= caps_lat[cnt_m1];
          end
        end
        S_MSG_WAIT: begin
          if (tx_valid && tx_ready) begin
            bit_lat  <= tx_bit;
            last_lat <= tx_last;
            state    <= S_MSG_SYM;
            cnt      <= '0;
            tx_ready <= 1'b0;
            // Both high lengths are at least 1, so every symbol opens high.
            str      <= 1'b1;
          end
        end
        S_MSG_SYM: begin
          if (cnt == SYM_LAST) begin
            cnt <= '0;
            if (last_lat) begin
              state <= S_MSG_END;
              str   <= 1'b1;
            end else begin
              state    <= S_MSG_WAIT;
              str      <= 1'b0;
              tx_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt_p1;
            str <= (cnt_p1 < hi_len);
          end
        end
        S_MSG_END: begin
          state     <= S_IDLE;
          str       <= 1'b0;
          done      <= 1'b1;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          str       <= 1'b0;
          mode      <= 1'b0;
          tx_ready  <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dms_ctrl.sv
module tb_dms_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_n = '0;
  logic [31:0] cfg_d = '0;
  logic [31:0] cfg_caps = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_bit = 1'b0;
  logic        tx_last = 1'b0;
  logic        str;
  logic        mode;
  logic        busy;
  logic        cfg_err;
  logic        done;

  int checks = 0;
  int errors = 0;

  dms_ctrl #(.SYM_LEN(8), .HI_LONG(6), .HI_SHORT(2)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_d(cfg_d), .cfg_caps(cfg_caps),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_bit(tx_bit), .tx_last(tx_last),
    .str(str), .mode(mode), .busy(busy),
    .cfg_err(cfg_err), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

  // Handshake a configuration and record str for every mode=1 cycle
  // (bounded at 100 cycles). poke pulses cfg_valid/tx_valid during CFG_D.
  task automatic run_config(input logic [3:0] n, input logic [31:0] d,
                            input logic [31:0] caps, input bit poke,
                            output int len, output logic [79:0] bits);
    logic [79:0] b;
    int l;
    cfg_n = n; cfg_d = d; cfg_caps = caps; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    b = '0;
    l = 0;
    while (mode === 1'b1 && l < 100) begin
      b = {b[78:0], str};
      l++;
      if (poke && l == 5) begin
        cfg_valid = 1'b1; cfg_d = 32'hFFFF_FFFF; cfg_n = 4'd1; tx_valid = 1'b1;
      end
      if (poke && l == 8) begin
        cfg_valid = 1'b0; tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    len = l;
    bits = b;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({str, mode, cfg_ready, tx_ready, busy, cfg_err, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {str, mode, cfg_ready, tx_ready, busy, cfg_err, done});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cfg_ready=%b busy=%b expected 1 0", cfg_ready, busy);
    end
  endtask

  task automatic test_cfg_err();
    cfg_n = 4'd6; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_err, busy, mode, str, cfg_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL cfg_err_pulse: {err,busy,mode,str,rdy}=%b expected 10001",
               {cfg_err, busy, mode, str, cfg_ready});
    end
    @(negedge clk);
    checks++;
    if ({cfg_err, busy, mode, str} !== 4'b0000) begin
      errors++;
      $display("FAIL cfg_err_clear: {err,busy,mode,str}=%b expected 0000",
               {cfg_err, busy, mode, str});
    end
  endtask

  task automatic check_n2_stream(input int len, input logic [79:0] bits, input bit poked);
    checks++;
    if (len !== 12) begin
      errors++;
      $display("FAIL cfg_n2_len(poke=%0d): got %0d expected 12", poked, len);
    end
    checks++;
    if (bits[11:0] !== 12'b0010_1001_0101) begin
      errors++;
      $display("FAIL cfg_n2_stream(poke=%0d): got %b expected 001010010101", poked, bits[11:0]);
    end
    checks++;
    if ({mode, str, tx_ready, cfg_ready, busy} !== 5'b00101) begin
      errors++;
      $display("FAIL cfg_n2_msg_wait(poke=%0d): {mode,str,txr,cfgr,busy}=%b expected 00101",
               poked, {mode, str, tx_ready, cfg_ready, busy});
    end
  endtask

  task automatic test_config_n2();
    int len;
    logic [79:0] bits;
    run_config(4'd2, 32'h0000_0009, 32'h0000_0005, 1'b0, len, bits);
    check_n2_stream(len, bits, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [18:0] got = '0;
    tx_valid = 1'b1; tx_bit = 1'b1; tx_last = 1'b0;
    for (int i = 0; i < 19; i++) begin
      got = {got[17:0], str};
      if (i == 1) begin
        tx_bit = 1'b0; tx_last = 1'b1;
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL msg_tx_ready_sym: got %b expected 0", tx_ready);
        end
      end
      if (i == 9) begin
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL msg_tx_ready_wait: got %b expected 1", tx_ready);
        end
      end
      if (i == 18) tx_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (got !== 19'b0_11111100_0_11000000_1) begin
      errors++;
      $display("FAIL msg_stream: got %b expected 0111111000110000001", got);
    end
    checks++;
    if ({done, busy, cfg_ready, str} !== 4'b1010) begin
      errors++;
      $display("FAIL msg_done: {done,busy,cfgr,str}=%b expected 1010",
               {done, busy, cfg_ready, str});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL msg_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_config_n5();
    int len;
    logic [79:0] bits;
    run_config(4'd5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, len, bits);
    checks++;
    if (len !== 68) begin
      errors++;
      $display("FAIL cfg_n5_len: got %0d expected 68", len);
    end
    checks++;
    if (bits[67:0] !== {4'b0101, 32'hFFFF_FFFF, 32'h0000_0000}) begin
      errors++;
      $display("FAIL cfg_n5_stream: got %h expected 5ffffffff00000000", bits[67:0]);
    end
  endtask

  task automatic test_reset_mid_symbol();
    int len;
    logic [79:0] bits;
    tx_valid = 1'b1; tx_bit = 1'b1; tx_last = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (str !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_high: str=%b expected 1", str);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({str, mode, busy, cfg_ready, tx_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL abort_immediate: {str,mode,busy,cfgr,txr}=%b expected 00000",
               {str, mode, busy, cfg_ready, tx_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cfg_ready, str, mode, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_release: {cfgr,str,mode,busy}=%b expected 1000",
               {cfg_ready, str, mode, busy});
    end
    // New configuration with cfg_valid/tx_valid pokes during CFG_D.
    run_config(4'd2, 32'h0000_0009, 32'h0000_0005, 1'b1, len, bits);
    check_n2_stream(len, bits, 1'b1);
  endtask

  initial begin
    test_reset();
    test_cfg_err();
    test_config_n2();
    test_back_to_back();
    test_config_n5();
    test_reset_mid_symbol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
